// File: rtl/car_layer_scheduler.sv
// Car sprite layer: per-pixel slot coverage, priority select, sprite-memory lookup
// and per-frame player/enemy collision flag. Two-cycle pixel pipeline.
module car_layer_scheduler #(
    parameter int NCARS = 4,
    parameter int SPR_W = 16,
    parameter int SPR_H = 32
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       de,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       frame_start,
    input  logic       pos_we,
    input  logic [1:0] pos_sel,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_en,
    output logic [4:0] mem_x,
    output logic [4:0] mem_y,
    output logic [2:0] mem_car,
    input  logic       mem_r,
    input  logic       mem_g,
    input  logic       mem_b,
    output logic       car_hit,
    output logic       car_r,
    output logic       car_g,
    output logic       car_b,
    output logic       collision
);

    localparam int unsigned IDX_W = (NCARS > 1) ? $clog2(NCARS) : 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } slot_t;

    slot_t shadow_tbl [NCARS];
    slot_t active_tbl [NCARS];

    logic [NCARS-1:0] cover_c;
    logic             win_valid_c;
    logic [IDX_W-1:0] win_idx_c;
    logic [4:0]       win_col_c;
    logic [4:0]       win_row_c;
    logic             multi_c;

    logic             s1_valid;
    logic             s1_multi;
    logic             sticky;
    logic             opaque_c;
    logic             set_c;

    // Position tables: CPU writes shadow, frame_start publishes shadow to active.
    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < NCARS; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NCARS; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                end
            end
            if (pos_we && (32'(pos_sel) < 32'(NCARS))) begin
                shadow_tbl[pos_sel] <= '{x: pos_x, y: pos_y, en: pos_en};
            end
        end
    end

    // Coverage in 11-bit unsigned so sprites never wrap past column/row 1023.
    always_comb begin
        cover_c = '0;
        for (int i = 0; i < NCARS; i++) begin
            cover_c[i] = de && active_tbl[i].en
                && ({1'b0, hcount} >= {1'b0, active_tbl[i].x})
                && (({1'b0, hcount} - {1'b0, active_tbl[i].x}) < 11'(SPR_W))
                && ({1'b0, vcount} >= {1'b0, active_tbl[i].y})
                && (({1'b0, vcount} - {1'b0, active_tbl[i].y}) < 11'(SPR_H));
        end
    end

    // Lowest index wins, so the player is drawn over every enemy.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int i = NCARS - 1; i >= 0; i--) begin
            if (cover_c[i]) begin
                win_valid_c = 1'b1;
                win_idx_c   = IDX_W'(i);
            end
        end
        win_col_c = 5'(hcount - active_tbl[win_idx_c].x);
        win_row_c = 5'(vcount - active_tbl[win_idx_c].y);
        multi_c   = cover_c[0] && (|cover_c[NCARS-1:1]);
    end

    // Stage 1: the sprite-memory address is itself the stage-1 register.
    always_ff @(posedge pclk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_multi <= 1'b0;
            mem_x    <= '0;
            mem_y    <= '0;
            mem_car  <= '0;
        end else begin
            s1_valid <= win_valid_c;
            s1_multi <= multi_c;
            mem_x    <= win_valid_c ? win_col_c : 5'd0;
            mem_y    <= win_valid_c ? win_row_c : 5'd0;
            mem_car  <= (win_valid_c && (win_idx_c != '0)) ? 3'd1 : 3'd0;
        end
    end

    assign opaque_c = s1_valid && (mem_r || mem_g || mem_b);
    assign set_c    = s1_multi && opaque_c;

    // Stage 2: pixel output and collision; a hit on the frame_start cycle
    // belongs to the frame that is closing.
    always_ff @(posedge pclk) begin
        if (reset) begin
            car_hit   <= 1'b0;
            car_r     <= 1'b0;
            car_g     <= 1'b0;
            car_b     <= 1'b0;
            sticky    <= 1'b0;
            collision <= 1'b0;
        end else begin
            car_hit <= opaque_c;
            car_r   <= opaque_c && mem_r;
            car_g   <= opaque_c && mem_g;
            car_b   <= opaque_c && mem_b;
            if (frame_start) begin
                collision <= sticky || set_c;
                sticky    <= 1'b0;
            end else begin
                sticky <= sticky || set_c;
            end
        end
    end

endmodule

// File: tb/tb_car_layer_scheduler.sv
// Directed bench for car_layer_scheduler: pipelined pixel vector table plus
// hand sequences for frame publishing, collision timing and reset.
module tb_car_layer_scheduler;

    logic       pclk;
    logic       reset;
    logic       de;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       frame_start;
    logic       pos_we;
    logic [1:0] pos_sel;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_en;
    logic [4:0] mem_x;
    logic [4:0] mem_y;
    logic [2:0] mem_car;
    logic       mem_r;
    logic       mem_g;
    logic       mem_b;
    logic       car_hit;
    logic       car_r;
    logic       car_g;
    logic       car_b;
    logic       collision;

    int checks = 0;
    int errors = 0;

    car_layer_scheduler dut (
        .pclk(pclk), .reset(reset), .de(de), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .pos_we(pos_we), .pos_sel(pos_sel),
        .pos_x(pos_x), .pos_y(pos_y), .pos_en(pos_en),
        .mem_x(mem_x), .mem_y(mem_y), .mem_car(mem_car),
        .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
        .car_hit(car_hit), .car_r(car_r), .car_g(car_g), .car_b(car_b),
        .collision(collision)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Sprite memory: column 7 transparent, player image 011, enemy image 110.
    assign {mem_r, mem_g, mem_b} = (mem_x == 5'd7) ? 3'b000 :
                                   (mem_car == 3'd0) ? 3'b011 : 3'b110;

    typedef struct {
        logic       de;
        logic [9:0] h;
        logic [9:0] v;
        logic [4:0] mx;
        logic [4:0] my;
        logic [2:0] mc;
        logic       hit;
        logic [2:0] rgb;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input logic d, input logic [9:0] h, input logic [9:0] v);
        de = d;
        hcount = h;
        vcount = v;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y, input logic en);
        pos_we = 1'b1;
        pos_sel = sel;
        pos_x = x;
        pos_y = y;
        pos_en = en;
        cyc();
        pos_we = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd100,  10'd50,  5'd0,  5'd0,  3'd1, 1'b1, 3'b110};
        vecs[1]  = '{1'b1, 10'd215,  10'd331, 5'd15, 5'd31, 3'd0, 1'b1, 3'b011};
        vecs[2]  = '{1'b1, 10'd216,  10'd300, 5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[3]  = '{1'b1, 10'd107,  10'd60,  5'd7,  5'd10, 3'd1, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 10'd207,  10'd305, 5'd7,  5'd5,  3'd0, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 10'd115,  10'd81,  5'd15, 5'd31, 3'd1, 1'b1, 3'b110};
        vecs[6]  = '{1'b1, 10'd99,   10'd50,  5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 10'd100,  10'd82,  5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[8]  = '{1'b0, 10'd1020, 10'd400, 5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 10'd1023, 10'd431, 5'd3,  5'd31, 3'd1, 1'b1, 3'b110};
        vecs[10] = '{1'b1, 10'd5,    10'd400, 5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[11] = '{1'b0, 10'd215,  10'd331, 5'd0,  5'd0,  3'd0, 1'b0, 3'b000};
        vecs[12] = '{1'b0, 10'd0,    10'd0,   5'd0,  5'd0,  3'd0, 1'b0, 3'b000};

        reset = 1'b1;
        frame_start = 1'b0;
        pos_we = 1'b0;
        pos_sel = '0;
        pos_x = '0;
        pos_y = '0;
        pos_en = 1'b0;
        pix(1'b0, 10'd0, 10'd0);
        repeat (3) cyc();
        chk("reset car_hit", 32'(car_hit), 32'd0);
        chk("reset rgb", 32'({car_r, car_g, car_b}), 32'd0);
        chk("reset mem", 32'({mem_x, mem_y, mem_car}), 32'd0);
        chk("reset collision", 32'(collision), 32'd0);
        reset = 1'b0;
        cyc();
        chk("post-reset car_hit", 32'(car_hit), 32'd0);

        wr(2'd1, 10'd100, 10'd50, 1'b1);
        wr(2'd0, 10'd200, 10'd300, 1'b1);
        wr(2'd2, 10'd200, 10'd300, 1'b1);
        wr(2'd3, 10'd1020, 10'd400, 1'b1);
        // Shadow only: nothing drawn before the frame boundary.
        pix(1'b1, 10'd100, 10'd50);
        cyc();
        cyc();
        chk("pre-frame car_hit", 32'(car_hit), 32'd0);
        pix(1'b0, 10'd0, 10'd0);
        fs();
        cyc();

        // Back-to-back pixels: mem_* of vector k and car_* of vector k-1.
        for (int k = 0; k < NVEC; k++) begin
            pix(vecs[k].de, vecs[k].h, vecs[k].v);
            cyc();
            chk($sformatf("v%0d mem_x", k), 32'(mem_x), 32'(vecs[k].mx));
            chk($sformatf("v%0d mem_y", k), 32'(mem_y), 32'(vecs[k].my));
            chk($sformatf("v%0d mem_car", k), 32'(mem_car), 32'(vecs[k].mc));
            if (k > 0) begin
                chk($sformatf("v%0d car_hit", k - 1), 32'(car_hit), 32'(vecs[k-1].hit));
                chk($sformatf("v%0d rgb", k - 1), 32'({car_r, car_g, car_b}), 32'(vecs[k-1].rgb));
            end
        end
        cyc();
        chk("collision mid-frame", 32'(collision), 32'd0);
        fs();
        chk("collision after frame", 32'(collision), 32'd1);

        // Write coinciding with frame_start lands in shadow only.
        pos_we = 1'b1;
        pos_sel = 2'd3;
        pos_x = 10'd500;
        pos_y = 10'd100;
        pos_en = 1'b1;
        frame_start = 1'b1;
        cyc();
        pos_we = 1'b0;
        frame_start = 1'b0;
        chk("collision cleared", 32'(collision), 32'd0);
        pix(1'b1, 10'd500, 10'd100);
        cyc();
        cyc();
        chk("slot3 not yet drawn", 32'(car_hit), 32'd0);
        pix(1'b0, 10'd0, 10'd0);
        fs();
        pix(1'b1, 10'd500, 10'd100);
        cyc();
        chk("slot3 mem_car", 32'(mem_car), 32'd1);
        cyc();
        chk("slot3 car_hit", 32'(car_hit), 32'd1);
        chk("slot3 rgb", 32'({car_r, car_g, car_b}), 32'b110);

        // Overlap whose stage-2 cycle coincides with frame_start.
        pix(1'b1, 10'd215, 10'd331);
        cyc();
        pix(1'b0, 10'd0, 10'd0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk("coincident collision", 32'(collision), 32'd1);
        cyc();
        fs();
        chk("coincident next frame", 32'(collision), 32'd0);

        // Reset mid-line while drawing, racing a write and frame_start.
        pix(1'b1, 10'd100, 10'd50);
        cyc();
        cyc();
        chk("pre-reset car_hit", 32'(car_hit), 32'd1);
        reset = 1'b1;
        frame_start = 1'b1;
        pos_we = 1'b1;
        pos_sel = 2'd1;
        pos_x = 10'd100;
        pos_y = 10'd50;
        pos_en = 1'b1;
        cyc();
        chk("mid reset car_hit", 32'(car_hit), 32'd0);
        chk("mid reset rgb", 32'({car_r, car_g, car_b}), 32'd0);
        chk("mid reset mem", 32'({mem_x, mem_y, mem_car}), 32'd0);
        chk("mid reset collision", 32'(collision), 32'd0);
        reset = 1'b0;
        frame_start = 1'b0;
        pos_we = 1'b0;
        cyc();
        chk("first cycle car_hit", 32'(car_hit), 32'd0);
        chk("first cycle mem", 32'({mem_x, mem_y, mem_car}), 32'd0);
        fs();
        cyc();
        chk("tables cleared mem", 32'({mem_x, mem_y, mem_car}), 32'd0);
        cyc();
        chk("tables cleared car_hit", 32'(car_hit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
